// File: rtl/gain_seq_pkg.sv
// Shared types and helpers for the PGA gain switch sequencer.
// Gain codes: bit1 drives stage-1 relay, bit0 drives stage-2 relay.
package gain_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STAGE2,
    SETTLE,
    HOLDOFF
  } seq_state_t;

  typedef logic [1:0] gain_code_t;

  localparam gain_code_t GAIN_MIN = 2'b00;

  // Lower of the two single-relay steps, so gain never overshoots mid-move
  function automatic gain_code_t intermediate_code(
    input gain_code_t cur,
    input gain_code_t tgt
  );
    gain_code_t a;
    gain_code_t b;
    a = {cur[1], tgt[0]};
    b = {tgt[1], cur[0]};
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// One instance is shared by the STAGE2, SETTLE and HOLDOFF states.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         adc_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/gain_switch_sequencer.sv
// Orders PGA relay changes, blanks ADC samples while settling,
// enforces a post-switch hold-off and an overload fast path to min gain.
import gain_seq_pkg::*;

module gain_switch_sequencer #(
  parameter int STEP_DELAY     = 200,
  parameter int SETTLE_CYCLES  = 2000,
  parameter int HOLDOFF_CYCLES = 256
) (
  input  logic        adc_clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [1:0]  req_gain,
  output logic        req_ready,
  input  logic        force_min,
  input  logic [11:0] adc_data_in,
  input  logic        adc_valid_in,
  output logic [1:0]  gain_out,
  output logic [11:0] adc_data_out,
  output logic        adc_valid_out,
  output logic        settled,
  output logic        busy,
  output logic [15:0] switch_count
);

  localparam int MAX_SD =
    (STEP_DELAY > SETTLE_CYCLES) ? STEP_DELAY : SETTLE_CYCLES;
  localparam int MAX_P =
    (MAX_SD > HOLDOFF_CYCLES) ? MAX_SD : HOLDOFF_CYCLES;
  localparam int TW = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0] LD_STEP   = TW'(STEP_DELAY - 1);
  localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] LD_HOLD   = TW'(HOLDOFF_CYCLES - 1);

  seq_state_t state_q, state_d;
  gain_code_t gain_d;
  gain_code_t tgt_q, tgt_d;
  logic       abort_q, abort_d;
  logic       tmr_load;
  logic [TW-1:0] tmr_val;
  logic       tmr_done;
  logic       cnt_inc;
  logic       force_act;
  logic       accept;
  gain_code_t diff;

  seq_timer #(
    .W (TW)
  ) u_timer (
    .adc_clk  (adc_clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign req_ready = (state_q == IDLE) && !force_min;
  assign accept    = req_valid && req_ready;
  assign diff      = req_gain ^ gain_out;
  assign settled   = (state_q == IDLE) || (state_q == HOLDOFF);
  assign busy      = (state_q == STAGE2) || (state_q == SETTLE);

  // Overload also restarts settling at min gain if a move is in flight
  assign force_act = force_min &&
    ((gain_out != GAIN_MIN) || busy);

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_out;
    tgt_d    = tgt_q;
    abort_d  = abort_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    cnt_inc  = 1'b0;
    if (force_act) begin
      gain_d   = GAIN_MIN;
      tgt_d    = GAIN_MIN;
      abort_d  = 1'b1;
      state_d  = SETTLE;
      tmr_load = 1'b1;
      tmr_val  = LD_SETTLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept && diff != 2'b00) begin
            tgt_d    = req_gain;
            abort_d  = 1'b0;
            tmr_load = 1'b1;
            unique case (1'b1)
              (diff == 2'b11): begin
                gain_d  = intermediate_code(gain_out, req_gain);
                state_d = STAGE2;
                tmr_val = LD_STEP;
              end
              default: begin
                gain_d  = req_gain;
                state_d = SETTLE;
                tmr_val = LD_SETTLE;
              end
            endcase
          end
        end
        STAGE2: begin
          if (tmr_done) begin
            gain_d   = tgt_q;
            state_d  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = LD_SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_done) begin
            cnt_inc  = !abort_q;
            state_d  = HOLDOFF;
            tmr_load = 1'b1;
            tmr_val  = LD_HOLD;
          end
        end
        HOLDOFF: begin
          if (tmr_done) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gain_out <= GAIN_MIN;
      tgt_q    <= GAIN_MIN;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_out <= gain_d;
      tgt_q    <= tgt_d;
      abort_q  <= abort_d;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_count <= '0;
    end else if (cnt_inc && switch_count != 16'hFFFF) begin
      switch_count <= switch_count + 16'd1;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_data_out  <= '0;
      adc_valid_out <= 1'b0;
    end else begin
      adc_data_out  <= adc_data_in;
      adc_valid_out <= adc_valid_in && settled;
    end
  end

endmodule

// File: tb/tb_gain_switch_sequencer.sv
// Randomized bench for gain_switch_sequencer against a timestamp-based
// reference model of the switching timeline.
module tb_gain_switch_sequencer;

  localparam int D = 4;
  localparam int S = 8;
  localparam int H = 3;

  logic        adc_clk;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_gain;
  logic        req_ready;
  logic        force_min;
  logic [11:0] adc_data_in;
  logic        adc_valid_in;
  logic [1:0]  gain_out;
  logic [11:0] adc_data_out;
  logic        adc_valid_out;
  logic        settled;
  logic        busy;
  logic [15:0] switch_count;

  gain_switch_sequencer #(
    .STEP_DELAY     (D),
    .SETTLE_CYCLES  (S),
    .HOLDOFF_CYCLES (H)
  ) dut (
    .adc_clk       (adc_clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_gain      (req_gain),
    .req_ready     (req_ready),
    .force_min     (force_min),
    .adc_data_in   (adc_data_in),
    .adc_valid_in  (adc_valid_in),
    .gain_out      (gain_out),
    .adc_data_out  (adc_data_out),
    .adc_valid_out (adc_valid_out),
    .settled       (settled),
    .busy          (busy),
    .switch_count  (switch_count)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  int n_chk;
  int n_pass;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: absolute edge indices at which each phase ends
  int         e;
  int         s2_end, st_end, ho_end;
  logic [1:0] m_gain, m_tgt;
  logic       m_abort;
  int         m_count;
  logic       m_vout;
  logic [11:0] m_dout;

  // 0 idle, 1 stage2, 2 settle, 3 holdoff
  function automatic int phase(input int k);
    if (k < s2_end) return 1;
    if (k < st_end) return 2;
    if (k < ho_end) return 3;
    return 0;
  endfunction

  function automatic logic [1:0] mid_code(input logic [1:0] c);
    logic [1:0] a, b;
    a = c ^ 2'b10;
    b = c ^ 2'b01;
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    s2_end = 0; st_end = 0; ho_end = 0;
    m_gain = 2'b00; m_tgt = 2'b00; m_abort = 1'b0;
    m_count = 0; m_vout = 1'b0; m_dout = '0;
  endtask

  task automatic model_step();
    int ph;
    ph = phase(e);
    m_vout = adc_valid_in && (ph == 0 || ph == 3);
    m_dout = adc_data_in;
    if (force_min && (m_gain != 2'b00 || ph == 1 || ph == 2)) begin
      m_gain = 2'b00;
      m_abort = 1'b1;
      s2_end = e + 1;
      st_end = e + 1 + S;
      ho_end = st_end + H;
    end else if (ph == 0) begin
      if (req_valid && !force_min && req_gain != m_gain) begin
        m_abort = 1'b0;
        m_tgt = req_gain;
        if ((req_gain ^ m_gain) == 2'b11) begin
          m_gain = mid_code(m_gain);
          s2_end = e + 1 + D;
        end else begin
          m_gain = req_gain;
          s2_end = e + 1;
        end
        st_end = s2_end + S;
        ho_end = st_end + H;
      end
    end else if (ph == 1) begin
      if (e == s2_end - 1) m_gain = m_tgt;
    end else if (ph == 2) begin
      if (e == st_end - 1 && !m_abort && m_count < 65535) m_count++;
    end
    e++;
  endtask

  task automatic check_outs();
    int ph;
    ph = phase(e);
    check("gain_out", 32'(gain_out), 32'(m_gain));
    check("adc_valid_out", 32'(adc_valid_out), 32'(m_vout));
    check("adc_data_out", 32'(adc_data_out), 32'(m_dout));
    check("switch_count", 32'(switch_count), 32'(m_count));
    check("settled", 32'(settled), 32'(ph == 0 || ph == 3));
    check("busy", 32'(busy), 32'(ph == 1 || ph == 2));
  endtask

  task automatic cyc(input logic rv, input logic [1:0] rg, input logic fm);
    req_valid = rv;
    req_gain = rg;
    force_min = fm;
    adc_data_in = 12'($urandom);
    adc_valid_in = 1'($urandom);
    #1;
    check("req_ready", 32'(req_ready), 32'(phase(e) == 0 && !fm));
    @(posedge adc_clk);
    model_step();
    #1;
    check_outs();
  endtask

  task automatic req(input logic [1:0] g);
    for (int n = 0; n < 200; n++) begin
      bit acc;
      acc = (phase(e) == 0);
      cyc(1'b1, g, 1'b0);
      if (acc) break;
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && phase(e) != 0; n++) cyc(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    e = 1;
    model_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_gain = 2'b00;
    force_min = 1'b0;
    adc_data_in = '0;
    adc_valid_in = 1'b1;
    repeat (2) @(posedge adc_clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    force_min = 1'b1;
    #1;
    check("rst_ready_force", 32'(req_ready), 32'd0);
    force_min = 1'b0;
    check_outs();
    rst_n = 1'b1;

    req(2'b01);
    wait_idle();
    req(2'b10);
    wait_idle();
    req(2'b00);
    wait_idle();
    req(2'b11);
    wait_idle();
    req(2'b00);
    wait_idle();
    req(2'b11);
    repeat (D + 2) cyc(1'b0, 2'b00, 1'b0);
    repeat (2) cyc(1'b0, 2'b00, 1'b1);
    wait_idle();
    req(m_gain);
    cyc(1'b0, 2'b00, 1'b0);
    req(2'b01);
    while (phase(e) != 3) cyc(1'b0, 2'b00, 1'b0);
    req(2'b10);
    wait_idle();

    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 2) == 0), 2'($urandom),
          1'($urandom_range(0, 49) == 0));
    end

    wait_idle();
    force dut.switch_count = 16'hFFFE;
    m_count = 16'hFFFE;
    cyc(1'b0, 2'b00, 1'b0);
    release dut.switch_count;
    for (int i = 0; i < 3; i++) begin
      req(m_gain ^ 2'b01);
      wait_idle();
    end
    check("sat_count", 32'(switch_count), 32'hFFFF);

    req(m_gain ^ 2'b11);
    repeat (2) cyc(1'b0, 2'b00, 1'b0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    s2_end = 0;
    check("async_rst_gain", 32'(gain_out), 32'd0);
    check("async_rst_count", 32'(switch_count), 32'd0);
    check("async_rst_settled", 32'(settled), 32'd1);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    check_outs();
    #2;
    rst_n = 1'b1;
    req(2'b10);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gain_switch_sequencer.md
# gain_switch_sequencer

Sequences analog gain changes requested by the auto-gain loop onto the two-stage PGA relay lines. Orders multi-bit code changes so gain never transiently overshoots, and blanks the ADC sample stream while the analog front end settles. Applies a post-switch hold-off against relay thrash, and provides an overload fast path to minimum gain. Sits between the gain-decision logic and the front-end relay drivers and downstream measurement path, all in the `adc_clk` domain.

## Interface
- STEP_DELAY, 200: cycles between the intermediate and final code on two-bit changes (≥1)
- SETTLE_CYCLES, 2000: blanking cycles after the final code is applied (≥1)
- HOLDOFF_CYCLES, 256: cycles after settling during which new requests are refused (≥1)
- adc_clk  in  1  sample clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  gain change request valid
- req_gain  in  2  requested gain code (00 lowest … 11 highest; bit1 = stage 1, bit0 = stage 2)
- req_ready  out  1  request accepted when req_valid && req_ready
- force_min  in  1  overload; level-sensitive, overrides everything
- adc_data_in  in  12  raw ADC sample
- adc_valid_in  in  1  sample strobe
- gain_out  out  2  relay drive code, registered
- adc_data_out  out  12  registered copy of adc_data_in
- adc_valid_out  out  1  adc_valid_in gated by settled, registered
- settled  out  1  front end stable (IDLE or HOLDOFF)
- busy  out  1  switching in progress (STAGE2 or SETTLE)
- switch_count  out  16  completed gain changes, saturating at 0xFFFF

## Operation
- States: IDLE, STAGE2, SETTLE, HOLDOFF. Reset enters IDLE.
- IDLE: req_ready = 1.
  - On accept with req_gain == gain_out: no action; remain IDLE; switch_count unchanged.
  - If exactly one bit differs: gain_out <= req_gain; go to SETTLE.
  - If both bits differ: gain_out <= intermediate; go to STAGE2.
- Intermediate code: the numerically lower of {cur[1],tgt[0]} and {tgt[1],cur[0]}.
  - 01↔10 uses 00; 00→11 and 11→00 use 01.
- STAGE2: hold for STEP_DELAY cycles, then gain_out <= target; go to SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to HOLDOFF.
  - switch_count increments (saturating) on the SETTLE→HOLDOFF transition, only for changes that were requested and not aborted.
- HOLDOFF: hold for HOLDOFF_CYCLES cycles, then go to IDLE. req_ready = 0; samples pass through.
- force_min = 1 in any state with gain_out ≠ 00:
  - gain_out <= 00; any pending target is discarded.
  - SETTLE timer restarts; switch_count is not incremented.
- force_min = 1 with gain_out == 00 in SETTLE: timer restarts.
- force_min = 1 with gain_out == 00 in IDLE/HOLDOFF: no effect.
- force_min has priority over a simultaneous request; that request is not accepted (req_ready drops in the same cycle).
- Outputs in the blanking states: req_ready = 0 in STAGE2, SETTLE and HOLDOFF. adc_valid_out = 0 in STAGE2 and SETTLE.

## Timing
- State timers load N−1 on entry and exit on reaching 0, so each state lasts exactly N cycles.
- Accept at edge T → gain_out changes at T+1.
- Two-bit change: final code at T+1+STEP_DELAY.
- req_ready returns at T+1+[STEP_DELAY]+SETTLE_CYCLES+HOLDOFF_CYCLES.
- settled and busy are decoded from the registered state.
- req_ready is combinational: (state == IDLE) && !force_min.
- Data path: 1-cycle latency. adc_valid_out(t+1) = adc_valid_in(t) && settled(t).
- Reset values:
  - 0: gain_out, adc_data_out, adc_valid_out, busy, switch_count
  - 1: settled
  - req_ready = !force_min
- Reset mid-switch: immediate return to gain 00 and IDLE. No settle period is enforced; the system integrator owns power-on settling.

## Structure
- Package gain_seq_pkg: state enum seq_state_t, typedef gain_code_t (logic [1:0]), function intermediate_code(cur, tgt), constant GAIN_MIN = 2'b00.
- Sub-module seq_timer: loadable down-counter with a done flag, shared by all three timed states. Width is $clog2 of the largest parameter.
- Top level: FSM, counter, data register.

## Test plan
Use STEP_DELAY=4, SETTLE_CYCLES=8, HOLDOFF_CYCLES=3.
- Request 00→01 at T → gain_out=01 at T+1. adc_valid_out low T+1..T+8 (SETTLE spans edges T+1..T+8). req_ready high at T+12. switch_count=1.
- Request 01→10 → gain_out 00 for 4 cycles, then 10. Total blanking 12 cycles; gain_out never reads 11.
- Request 00→11 → intermediate 01, then 11. Request 11→00 → intermediate 01, then 00.
- force_min pulse 2 cycles into SETTLE of a 00→11 change → gain_out=00 next cycle. SETTLE restarts for 8 cycles; switch_count unchanged.
- Request equal to current code → accepted in 1 cycle; no blanking; count unchanged. Request during HOLDOFF → req_ready=0, held until IDLE, then accepted.
- 65 540 forced-count completions (or preload via force) → switch_count saturates at 0xFFFF. Asserting rst_n low mid-STAGE2 → all outputs at reset values asynchronously.
